// File: rtl/tsb_pkg.sv
// Shared types and width helpers for the tri-state bus arbiter slice.
package tsb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DEAD  = 2'd2
    } tsb_state_t;

    function automatic int idw_f(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int holdw_f(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: first set request after last_owner, wrapping modulo N.
module rr_priority_pick
    import tsb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = idw_f(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_owner,
    output logic           any,
    output logic [IDW-1:0] pick
);

    int cand;

    // Scan from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        cand = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = (int'(last_owner) + 1 + i) % N;
            if (req[cand]) begin
                any  = 1'b1;
                pick = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Enable generator for a shared notif1 bus: round-robin grant, break-before-make
// dead time between owners, and a hold timeout that revokes long tenures.
module tristate_bus_arbiter
    import tsb_pkg::*;
#(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int MAX_HOLD    = 8,
    localparam int IDW        = idw_f(N),
    localparam int HOLDW      = holdw_f(MAX_HOLD)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   en,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout,
    output logic [1:0]     state_dbg
);

    // Handshake: req is a level; a grant is held while req[gnt_id] stays high
    // (up to MAX_HOLD cycles) and released the cycle after it drops.

    tsb_state_t       state;
    logic [HOLDW-1:0] hold_cnt;
    logic [3:0]       dead_cnt;
    logic [IDW-1:0]   last_owner;
    logic             pick_any;
    logic [IDW-1:0]   pick_id;
    logic [N-1:0]     pick_onehot;

    rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .any        (pick_any),
        .pick       (pick_id)
    );

    always_comb begin
        pick_onehot          = '0;
        pick_onehot[pick_id] = 1'b1;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            en         <= '0;
            gnt_valid  <= 1'b0;
            gnt_id     <= '0;
            timeout    <= 1'b0;
            hold_cnt   <= '0;
            dead_cnt   <= '0;
            last_owner <= IDW'(N - 1);
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state     <= GRANT;
                        en        <= pick_onehot;
                        gnt_id    <= pick_id;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLDW'(1);
                    end
                end
                GRANT: begin
                    if (req[gnt_id] && (hold_cnt < HOLDW'(MAX_HOLD))) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        // Voluntary release or revoke; timeout marks the revoke case.
                        state      <= DEAD;
                        en         <= '0;
                        gnt_valid  <= 1'b0;
                        last_owner <= gnt_id;
                        timeout    <= req[gnt_id];
                        hold_cnt   <= '0;
                        dead_cnt   <= 4'd1;
                    end
                end
                DEAD: begin
                    if (dead_cnt >= 4'(DEAD_CYCLES)) begin
                        state    <= IDLE;
                        dead_cnt <= '0;
                    end else begin
                        dead_cnt <= dead_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    en        <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed and random bench for tristate_bus_arbiter with a per-cycle invariant monitor.
module tb_tristate_bus_arbiter;
    import tsb_pkg::*;

    localparam int N           = 4;
    localparam int DEAD_CYCLES = 1;
    localparam int MAX_HOLD    = 8;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] en;
    logic         gnt_valid;
    logic [1:0]   gnt_id;
    logic         timeout;
    logic [1:0]   state_dbg;

    int checks   = 0;
    int failures = 0;

    tristate_bus_arbiter #(.N(N), .DEAD_CYCLES(DEAD_CYCLES), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .en        (en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // per-cycle invariant monitor
    logic [N-1:0] prev_en;
    int           zero_run;
    int           high_run;
    int           last_id;
    bit           have_owner;
    int           cur;

    initial begin
        prev_en    = '0;
        zero_run   = 0;
        high_run   = 0;
        last_id    = 0;
        have_owner = 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_en    = '0;
            zero_run   = 0;
            high_run   = 0;
            have_owner = 1'b0;
        end else begin
            checks++;
            if (($countones(en) > 1) || (gnt_valid !== (|en))) begin
                failures++;
                $display("FAIL inv_onehot en=%b gnt_valid=%b", en, gnt_valid);
            end
            checks++;
            if (timeout && !((en == '0) && (prev_en != '0))) begin
                failures++;
                $display("FAIL inv_timeout timeout=%b en=%b prev_en=%b", timeout, en, prev_en);
            end
            if (en != '0) begin
                cur = 0;
                for (int k = 0; k < N; k++) if (en[k]) cur = k;
                checks++;
                if ((prev_en != '0) && (en != prev_en)) begin
                    failures++;
                    $display("FAIL inv_gap direct switch got=%b prev=%b", en, prev_en);
                end else if ((prev_en == '0) && have_owner && (cur != last_id) && (zero_run < DEAD_CYCLES + 1)) begin
                    failures++;
                    $display("FAIL inv_gap zero_cycles got=%0d need=%0d", zero_run, DEAD_CYCLES + 1);
                end
                high_run++;
                checks++;
                if (high_run > MAX_HOLD) begin
                    failures++;
                    $display("FAIL inv_hold tenure got=%0d max=%0d", high_run, MAX_HOLD);
                end
                zero_run   = 0;
                last_id    = cur;
                have_owner = 1'b1;
            end else begin
                zero_run++;
                high_run = 0;
            end
            prev_en = en;
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        req = '0;
        n = 0;
        while (!((state_dbg == 2'(IDLE)) && (en == '0)) && (n < 20)) begin
            tick();
            n++;
        end
        checks++;
        if (!((state_dbg == 2'(IDLE)) && (en == '0))) begin
            failures++;
            $display("FAIL wait_idle state=%0d en=%b after %0d cycles", state_dbg, en, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b1111;
        tick();
        tick();
        checks++;
        if ((en !== 4'b0000) || (gnt_valid !== 1'b0) || (gnt_id !== 2'd0) || (timeout !== 1'b0)) begin
            failures++;
            $display("FAIL reset_outputs en=%b gv=%b id=%0d to=%b exp 0000/0/0/0", en, gnt_valid, gnt_id, timeout);
        end
        checks++;
        if (state_dbg !== 2'(IDLE)) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=%0d", state_dbg, IDLE);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ((en !== 4'b0001) || (gnt_id !== 2'd0) || (gnt_valid !== 1'b1)) begin
            failures++;
            $display("FAIL reset_first_grant en=%b id=%0d gv=%b exp 0001/0/1", en, gnt_id, gnt_valid);
        end
        wait_idle();
    endtask

    task automatic test_single();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ((en !== 4'b0100) || (gnt_id !== 2'd2) || (timeout !== 1'b0)) begin
                failures++;
                $display("FAIL single_tenure cyc=%0d en=%b id=%0d to=%b exp 0100/2/0", i, en, gnt_id, timeout);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if ((en !== 4'b0000) || (timeout !== 1'b0) || (state_dbg !== 2'(DEAD))) begin
            failures++;
            $display("FAIL single_release en=%b to=%b state=%0d exp 0000/0/%0d", en, timeout, state_dbg, DEAD);
        end
        tick();
        checks++;
        if ((en !== 4'b0000) || (state_dbg !== 2'(IDLE))) begin
            failures++;
            $display("FAIL single_idle en=%b state=%0d exp 0000/%0d", en, state_dbg, IDLE);
        end
        tick();
        checks++;
        if ((en !== 4'b0000) || (gnt_id !== 2'd2)) begin
            failures++;
            $display("FAIL single_quiet en=%b id=%0d exp 0000/2", en, gnt_id);
        end
    endtask

    task automatic test_round_robin();
        int           owners[5];
        logic [N-1:0] exp_en;
        owners = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        req   = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            exp_en = 4'b0001 << owners[t];
            for (int c = 0; c < MAX_HOLD; c++) begin
                tick();
                checks++;
                if ((en !== exp_en) || (gnt_id !== 2'(owners[t])) || (timeout !== 1'b0)) begin
                    failures++;
                    $display("FAIL rr_tenure t=%0d c=%0d en=%b id=%0d to=%b exp %b/%0d/0",
                             t, c, en, gnt_id, timeout, exp_en, owners[t]);
                end
            end
            tick();
            checks++;
            if ((en !== 4'b0000) || (timeout !== 1'b1)) begin
                failures++;
                $display("FAIL rr_revoke t=%0d en=%b to=%b exp 0000/1", t, en, timeout);
            end
            tick();
            checks++;
            if ((en !== 4'b0000) || (timeout !== 1'b0)) begin
                failures++;
                $display("FAIL rr_gap t=%0d en=%b to=%b exp 0000/0", t, en, timeout);
            end
        end
        wait_idle();
    endtask

    task automatic test_no_preempt();
        req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (en !== 4'b0100) begin
                failures++;
                $display("FAIL nopre_hold cyc=%0d got=%b exp=0100", i, en);
            end
        end
        req = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (en !== 4'b0100) begin
                failures++;
                $display("FAIL nopre_contend cyc=%0d got=%b exp=0100", i, en);
            end
        end
        req = 4'b0001;
        tick();
        checks++;
        if (en !== 4'b0000) begin
            failures++;
            $display("FAIL nopre_dead got=%b exp=0000", en);
        end
        tick();
        checks++;
        if (en !== 4'b0000) begin
            failures++;
            $display("FAIL nopre_idle got=%b exp=0000", en);
        end
        tick();
        checks++;
        if ((en !== 4'b0001) || (gnt_id !== 2'd0)) begin
            failures++;
            $display("FAIL nopre_next en=%b id=%0d exp 0001/0", en, gnt_id);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (en !== 4'b1000) begin
                failures++;
                $display("FAIL midrst_hold cyc=%0d got=%b exp=1000", i, en);
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if ((en !== 4'b0000) || (gnt_valid !== 1'b0) || (gnt_id !== 2'd0) || (timeout !== 1'b0)) begin
            failures++;
            $display("FAIL midrst_clear en=%b gv=%b id=%0d to=%b exp 0000/0/0/0", en, gnt_valid, gnt_id, timeout);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ((en !== 4'b1000) || (gnt_id !== 2'd3) || (gnt_valid !== 1'b1)) begin
            failures++;
            $display("FAIL midrst_regrant en=%b id=%0d gv=%b exp 1000/3/1", en, gnt_id, gnt_valid);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (en !== 4'b1000) begin
            failures++;
            $display("FAIL midrst_keep got=%b exp=1000", en);
        end
        req = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (en !== 4'b0001) begin
            failures++;
            $display("FAIL midrst_handoff got=%b exp=0001", en);
        end
        wait_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            req = 4'($urandom_range(0, 15));
            tick();
        end
        wait_idle();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_no_preempt();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
